// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the round referee.
//   ref_state_e         - referee FSM state encoding
//   DEF_ROUND_FRAMES    - default frames to survive for a win
//   DEF_MAX_OUT_FRAMES  - default consecutive unsafe frames causing a loss
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_PAUSE,
        ST_DONE
    } ref_state_e;

    localparam int unsigned DEF_ROUND_FRAMES   = 1800;
    localparam int unsigned DEF_MAX_OUT_FRAMES = 15;

endpackage

// File: rtl/frame_sampler.sv
// frame_sampler: derives the per-frame tick from the scan position and
// captures the safe flag under the ball centre during each frame.
//   clk, rst        - clock, synchronous active-high reset
//   screen_x_i/y_i  - current scan position
//   is_safe_i       - safe flag for the current scan position
//   ball_x_i/y_i    - ball centre
//   tick_o          - first cycle of a frame (scan enters (0,0))
//   sample_safe_o   - verdict for the frame that just ended (valid with tick_o);
//                     a frame in which the ball was never scanned counts as safe
module frame_sampler #(
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [XW-1:0] screen_x_i,
    input  logic [YW-1:0] screen_y_i,
    input  logic          is_safe_i,
    input  logic [XW-1:0] ball_x_i,
    input  logic [YW-1:0] ball_y_i,
    output logic          tick_o,
    output logic          sample_safe_o
);

    logic at_origin;
    logic ball_hit;
    logic prev_origin_q;
    logic primed_q;
    logic sample_q;
    logic sampled_q;

    assign at_origin = (screen_x_i == '0) && (screen_y_i == '0);
    assign ball_hit  = (screen_x_i == ball_x_i) && (screen_y_i == ball_y_i);

    // primed_q suppresses a tick in the very first cycle after reset even
    // though the previous-origin flag is cleared by reset.
    assign tick_o        = at_origin && !prev_origin_q && primed_q;
    assign sample_safe_o = !sampled_q || sample_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_origin_q <= 1'b0;
            primed_q      <= 1'b0;
            sample_q      <= 1'b0;
            sampled_q     <= 1'b0;
        end else begin
            prev_origin_q <= at_origin;
            primed_q      <= 1'b1;
            // A hit in the tick cycle itself belongs to the new frame, so it
            // takes priority over the clear.
            if (ball_hit) begin
                sample_q  <= is_safe_i;
                sampled_q <= 1'b1;
            end else if (tick_o) begin
                sample_q  <= 1'b0;
                sampled_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/round_referee.sv
// round_referee: decides win/loss of a round from per-frame ball safety.
//   clk, rst          - clock, synchronous active-high reset
//   i_game_running    - game running (0 = paused)
//   i_level_rdy       - level generated and valid (0 = regeneration/abort)
//   i_screen_x/y      - current scan position
//   i_is_safe         - safe flag for the current scan position
//   i_ball_x/y        - ball centre
//   o_round_ended     - one-cycle pulse on round end
//   o_is_win          - round result, held until the next round starts
//   o_time_left       - remaining frames
//   o_out_count       - consecutive unsafe frames
module round_referee
    import game_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH   = 800,
    parameter int unsigned SCREEN_HEIGHT  = 600,
    parameter int unsigned ROUND_FRAMES   = DEF_ROUND_FRAMES,
    parameter int unsigned MAX_OUT_FRAMES = DEF_MAX_OUT_FRAMES
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_game_running,
    input  logic                                i_level_rdy,
    input  logic [$clog2(SCREEN_WIDTH)-1:0]     i_screen_x,
    input  logic [$clog2(SCREEN_HEIGHT)-1:0]    i_screen_y,
    input  logic                                i_is_safe,
    input  logic [$clog2(SCREEN_WIDTH)-1:0]     i_ball_x,
    input  logic [$clog2(SCREEN_HEIGHT)-1:0]    i_ball_y,
    output logic                                o_round_ended,
    output logic                                o_is_win,
    output logic [$clog2(ROUND_FRAMES+1)-1:0]   o_time_left,
    output logic [$clog2(MAX_OUT_FRAMES+1)-1:0] o_out_count
);

    localparam int unsigned XW = $clog2(SCREEN_WIDTH);
    localparam int unsigned YW = $clog2(SCREEN_HEIGHT);
    localparam int unsigned TW = $clog2(ROUND_FRAMES + 1);
    localparam int unsigned OW = $clog2(MAX_OUT_FRAMES + 1);

    localparam logic [TW-1:0] TIME_INIT = TW'(ROUND_FRAMES);
    localparam logic [OW-1:0] OUT_MAX   = OW'(MAX_OUT_FRAMES);

    ref_state_e    state_q, state_d;
    logic [TW-1:0] time_q, time_d;
    logic [OW-1:0] out_q, out_d;
    logic          win_q, win_d;
    logic          ended_q, ended_d;

    logic          tick;
    logic          sample_safe;
    logic          play_tick;
    logic [TW-1:0] time_dec;
    logic [OW-1:0] out_inc;
    logic [OW-1:0] frame_out;

    frame_sampler #(
        .XW (XW),
        .YW (YW)
    ) u_sampler (
        .clk           (clk),
        .rst           (rst),
        .screen_x_i    (i_screen_x),
        .screen_y_i    (i_screen_y),
        .is_safe_i     (i_is_safe),
        .ball_x_i      (i_ball_x),
        .ball_y_i      (i_ball_y),
        .tick_o        (tick),
        .sample_safe_o (sample_safe)
    );

    // Saturating counter updates for the frame that just ended.
    assign time_dec  = (time_q == '0) ? '0 : time_q - 1'b1;
    assign out_inc   = (out_q == OUT_MAX) ? OUT_MAX : out_q + 1'b1;
    assign frame_out = sample_safe ? '0 : out_inc;
    assign play_tick = (state_q == ST_PLAY) && i_level_rdy && i_game_running && tick;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            time_q  <= '0;
            out_q   <= '0;
            win_q   <= 1'b0;
            ended_q <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            out_q   <= out_d;
            win_q   <= win_d;
            ended_q <= ended_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_game_running && i_level_rdy) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (!i_level_rdy) begin
                    state_d = ST_IDLE;
                end else if (!i_game_running) begin
                    state_d = ST_PAUSE;
                end else if (tick && ((frame_out == OUT_MAX) || (time_dec == '0))) begin
                    state_d = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (!i_level_rdy) begin
                    state_d = ST_IDLE;
                end else if (i_game_running) begin
                    state_d = ST_PLAY;
                end
            end
            ST_DONE: begin
                if (!i_level_rdy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / counter logic
    always_comb begin
        time_d  = time_q;
        out_d   = out_q;
        win_d   = win_q;
        ended_d = (state_d == ST_DONE) && (state_q != ST_DONE);
        if ((state_q == ST_IDLE) && (state_d == ST_PLAY)) begin
            time_d = TIME_INIT;
            out_d  = '0;
            win_d  = 1'b0;
        end else if (play_tick) begin
            time_d = time_dec;
            out_d  = frame_out;
            // A loss on the same tick as timer expiry still counts as a loss.
            if (state_d == ST_DONE) win_d = (frame_out != OUT_MAX);
        end
    end

    assign o_round_ended = ended_q;
    assign o_is_win      = win_q;
    assign o_time_left   = time_q;
    assign o_out_count   = out_q;

endmodule

// File: tb/tb_round_referee.sv
// tb_round_referee: randomized and directed stimulus for round_referee on an
// 8x6 screen with ROUND_FRAMES=4, MAX_OUT_FRAMES=2, checked against a
// frame-level reference model.
module tb_round_referee;

    localparam int RF = 4;
    localparam int MO = 2;
    localparam int FC = 48; // cycles per 8x6 frame

    logic       clk = 1'b0;
    logic       rst;
    logic       game_running;
    logic       level_rdy;
    logic [2:0] scan_x;
    logic [2:0] scan_y;
    logic       is_safe;
    logic [2:0] ball_x;
    logic [2:0] ball_y;
    logic       round_ended;
    logic       is_win;
    logic [2:0] time_left;
    logic [1:0] out_count;

    always #5 clk = ~clk;

    round_referee #(
        .SCREEN_WIDTH   (8),
        .SCREEN_HEIGHT  (6),
        .ROUND_FRAMES   (RF),
        .MAX_OUT_FRAMES (MO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_game_running (game_running),
        .i_level_rdy    (level_rdy),
        .i_screen_x     (scan_x),
        .i_screen_y     (scan_y),
        .i_is_safe      (is_safe),
        .i_ball_x       (ball_x),
        .i_ball_y       (ball_y),
        .o_round_ended  (round_ended),
        .o_is_win       (is_win),
        .o_time_left    (time_left),
        .o_out_count    (out_count)
    );

    int checks = 0;
    int errors = 0;

    // Per-frame scenario description
    bit f_safe [0:15];
    bit f_run  [0:15];
    bit f_nos  [0:15];
    int n_frames;
    int abort_at;
    int abort_kind; // 1: level_rdy drop, 2: reset

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_frames();
        for (int i = 0; i < 16; i++) begin
            f_safe[i] = 1'b1;
            f_run[i]  = 1'b1;
            f_nos[i]  = 1'b0;
        end
        abort_at   = -1;
        abort_kind = 0;
    endtask

    task automatic run_round(input bit do_reset);
        int  m_time;
        int  m_out;
        int  m_end;
        bit  m_win;
        int  pulses;
        int  pulse_at;
        int  bx;
        int  by;
        int  p;
        m_time = RF; m_out = 0; m_end = -1; m_win = 1'b0;
        pulses = 0; pulse_at = -1; bx = 1; by = 0;
        scan_x = '0; scan_y = '0; is_safe = 1'b0; ball_x = 3'd1; ball_y = 3'd0;
        if (do_reset) begin
            rst = 1'b1;
            game_running = 1'($urandom % 2);
            level_rdy    = 1'($urandom % 2);
            step();
            rst = 1'b0;
            chk("rst_ended", round_ended, 0);
            chk("rst_win", is_win, 0);
            chk("rst_time", time_left, 0);
            chk("rst_out", out_count, 0);
        end
        game_running = 1'b1;
        level_rdy    = 1'b1;
        repeat (3) step();
        chk("start_ended", round_ended, 0);
        chk("start_win", is_win, 0);
        chk("start_time", time_left, RF);
        chk("start_out", out_count, 0);

        for (int f = 0; f <= n_frames; f++) begin
            for (int c = 0; c < FC; c++) begin
                if (f == n_frames && c > 0) break;
                scan_x = 3'(c % 8);
                scan_y = 3'(c / 8);
                if (c == 0 && f < n_frames) begin
                    bx = $urandom_range(0, 7);
                    by = f_nos[f] ? 6 : $urandom_range(0, 5);
                    if (bx == 0 && by == 0) bx = 1;
                    ball_x = 3'(bx);
                    ball_y = 3'(by);
                end
                if (c == 1) game_running = f_run[f];
                if (f == abort_at && c == 10) begin
                    if (abort_kind == 1) level_rdy = 1'b0;
                    if (abort_kind == 2) rst = 1'b1;
                end
                if (f == abort_at && c == 11 && abort_kind == 2) begin
                    rst = 1'b0;
                    level_rdy = 1'b0;
                end
                is_safe = ((c % 8) == bx && (c / 8) == by) ? f_safe[f] : 1'($urandom % 2);
                step();
                if (round_ended) begin
                    pulses++;
                    pulse_at = f * FC + c;
                end
                if (f == abort_at && c == 10 && abort_kind == 2) begin
                    chk("abort_rst_ended", round_ended, 0);
                    chk("abort_rst_win", is_win, 0);
                    chk("abort_rst_time", time_left, 0);
                    chk("abort_rst_out", out_count, 0);
                end
                if (c == 0 && f > 0) begin
                    p = f - 1;
                    if (!(abort_at >= 0 && p >= abort_at)) begin
                        if (m_end < 0 && f_run[p]) begin
                            m_out  = (f_safe[p] || f_nos[p]) ? 0 : ((m_out + 1 > MO) ? MO : m_out + 1);
                            m_time = (m_time > 0) ? m_time - 1 : 0;
                            if (m_out == MO) begin
                                m_end = p; m_win = 1'b0;
                            end else if (m_time == 0) begin
                                m_end = p; m_win = 1'b1;
                            end
                        end
                        chk("out_count", out_count, m_out);
                        chk("time_left", time_left, m_time);
                    end
                end
            end
        end
        chk("pulse_count", pulses, (m_end >= 0) ? 1 : 0);
        if (m_end >= 0) chk("pulse_at", pulse_at, (m_end + 1) * FC);
        chk("is_win", is_win, m_win);
    endtask

    initial begin
        rst = 1'b1; game_running = 1'b0; level_rdy = 1'b0;
        scan_x = '0; scan_y = '0; is_safe = 1'b0; ball_x = 3'd1; ball_y = 3'd0;
        step();

        // All safe: win after 4 frames, DONE ignores the extra frame
        clear_frames(); n_frames = 5;
        run_round(1'b1);

        // Level regeneration after a win, result held, then a fresh round
        level_rdy = 1'b0; scan_x = '0; scan_y = '0;
        repeat (2) step();
        chk("held_win", is_win, 1);
        chk("held_ended", round_ended, 0);
        clear_frames(); n_frames = 4;
        f_safe[1] = 1'b0;
        run_round(1'b0);

        // Two unsafe frames: loss
        clear_frames(); n_frames = 3;
        f_safe[0] = 1'b0; f_safe[1] = 1'b0;
        run_round(1'b1);

        // Unsafe, safe, unsafe: counter resets, still a win
        clear_frames(); n_frames = 4;
        f_safe[0] = 1'b0; f_safe[2] = 1'b0;
        run_round(1'b1);

        // Unsafe on the last two frames: loss beats timer expiry
        clear_frames(); n_frames = 4;
        f_safe[2] = 1'b0; f_safe[3] = 1'b0;
        run_round(1'b1);

        // Pause for three frames mid-round
        clear_frames(); n_frames = 8;
        f_run[2] = 1'b0; f_run[3] = 1'b0; f_run[4] = 1'b0;
        run_round(1'b1);

        // Ball never scanned: frames count as safe despite unsafe flag
        clear_frames(); n_frames = 5;
        for (int i = 0; i < 16; i++) begin
            f_safe[i] = 1'b0;
            f_nos[i]  = 1'b1;
        end
        run_round(1'b1);

        // Level aborted mid-round
        clear_frames(); n_frames = 5;
        abort_at = 1; abort_kind = 1;
        run_round(1'b1);

        // Reset mid-round
        clear_frames(); n_frames = 5;
        abort_at = 2; abort_kind = 2;
        run_round(1'b1);

        // Randomized rounds
        for (int r = 0; r < 20; r++) begin
            clear_frames();
            n_frames = $urandom_range(6, 10);
            for (int i = 0; i < 16; i++) begin
                f_safe[i] = ($urandom_range(0, 9) < 7);
                f_run[i]  = ($urandom_range(0, 9) < 8);
                f_nos[i]  = ($urandom_range(0, 19) < 3);
            end
            run_round(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
